// File: rtl/triangle_bbox_scanner.sv
// rtl/triangle_bbox_scanner.sv - latches a triangle, computes its bounding box, streams every box point in raster order
module triangle_bbox_scanner #(
    parameter int SYS_BIT_WIDTH = 6
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     tri_valid_in,
    output logic                     tri_ready_out,
    input  logic [SYS_BIT_WIDTH-1:0] vertex_ax,
    input  logic [SYS_BIT_WIDTH-1:0] vertex_ay,
    input  logic [SYS_BIT_WIDTH-1:0] vertex_bx,
    input  logic [SYS_BIT_WIDTH-1:0] vertex_by,
    input  logic [SYS_BIT_WIDTH-1:0] vertex_cx,
    input  logic [SYS_BIT_WIDTH-1:0] vertex_cy,
    output logic                     point_valid_out,
    input  logic                     point_ready_in,
    output logic [SYS_BIT_WIDTH-1:0] point_x,
    output logic [SYS_BIT_WIDTH-1:0] point_y,
    output logic [SYS_BIT_WIDTH-1:0] vertex_ax_out,
    output logic [SYS_BIT_WIDTH-1:0] vertex_ay_out,
    output logic [SYS_BIT_WIDTH-1:0] vertex_bx_out,
    output logic [SYS_BIT_WIDTH-1:0] vertex_by_out,
    output logic [SYS_BIT_WIDTH-1:0] vertex_cx_out,
    output logic [SYS_BIT_WIDTH-1:0] vertex_cy_out,
    output logic                     last_out,
    output logic                     busy_out
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BBOX,
        ST_SCAN
    } state_t;

    localparam logic [SYS_BIT_WIDTH-1:0] ONE = {{(SYS_BIT_WIDTH-1){1'b0}}, 1'b1};

    state_t                   state_q;
    logic [SYS_BIT_WIDTH-1:0] ax_q, ay_q, bx_q, by_q, cx_q, cy_q;
    logic [SYS_BIT_WIDTH-1:0] xmin_q, xmax_q, ymin_q, ymax_q;
    logic [SYS_BIT_WIDTH-1:0] xmin_d, xmax_d, ymin_d, ymax_d;
    logic [SYS_BIT_WIDTH-1:0] x_q, y_q;
    logic                     valid_q;
    logic                     ready_q;
    logic                     busy_q;
    logic                     x_end, y_end;

    function automatic logic [SYS_BIT_WIDTH-1:0] min3(
        input logic [SYS_BIT_WIDTH-1:0] a,
        input logic [SYS_BIT_WIDTH-1:0] b,
        input logic [SYS_BIT_WIDTH-1:0] c
    );
        logic [SYS_BIT_WIDTH-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [SYS_BIT_WIDTH-1:0] max3(
        input logic [SYS_BIT_WIDTH-1:0] a,
        input logic [SYS_BIT_WIDTH-1:0] b,
        input logic [SYS_BIT_WIDTH-1:0] c
    );
        logic [SYS_BIT_WIDTH-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // Box is derived from the latched vertices, so input changes after the handshake cannot disturb it
    assign xmin_d = min3(ax_q, bx_q, cx_q);
    assign xmax_d = max3(ax_q, bx_q, cx_q);
    assign ymin_d = min3(ay_q, by_q, cy_q);
    assign ymax_d = max3(ay_q, by_q, cy_q);

    // Equality-only termination keeps a box edge at the top code from ever wrapping
    assign x_end = (x_q == xmax_q);
    assign y_end = (y_q == ymax_q);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
            ax_q    <= '0;
            ay_q    <= '0;
            bx_q    <= '0;
            by_q    <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymin_q  <= '0;
            ymax_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tri_valid_in && ready_q) begin
                        ax_q    <= vertex_ax;
                        ay_q    <= vertex_ay;
                        bx_q    <= vertex_bx;
                        by_q    <= vertex_by;
                        cx_q    <= vertex_cx;
                        cy_q    <= vertex_cy;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_BBOX;
                    end
                end
                ST_BBOX: begin
                    xmin_q  <= xmin_d;
                    xmax_q  <= xmax_d;
                    ymin_q  <= ymin_d;
                    ymax_q  <= ymax_d;
                    state_q <= ST_SCAN;
                end
                ST_SCAN: begin
                    // First SCAN cycle primes the point registers from the registered box
                    if (!valid_q) begin
                        x_q     <= xmin_q;
                        y_q     <= ymin_q;
                        valid_q <= 1'b1;
                    end else if (point_ready_in) begin
                        if (!x_end) begin
                            x_q <= x_q + ONE;
                        end else if (!y_end) begin
                            x_q <= xmin_q;
                            y_q <= y_q + ONE;
                        end else begin
                            valid_q <= 1'b0;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tri_ready_out   = ready_q;
    assign point_valid_out = valid_q;
    assign busy_out        = busy_q;
    assign point_x         = x_q;
    assign point_y         = y_q;
    assign vertex_ax_out   = ax_q;
    assign vertex_ay_out   = ay_q;
    assign vertex_bx_out   = bx_q;
    assign vertex_by_out   = by_q;
    assign vertex_cx_out   = cx_q;
    assign vertex_cy_out   = cy_q;
    assign last_out        = (state_q == ST_SCAN) && valid_q && x_end && y_end;

endmodule
